lsu_ctrl: RTL and testbench

Load/store sequencer between the decoder-driven memory stage and a data-memory bus with a request/grant/response handshake. It takes the `memread`/`memwrite` controls plus `funct3` and the effective address, and stalls the pipeline while the access is outstanding. It also generates byte enables and write-data lane replication, and returns a sign- or zero-extended load result. Misaligned and illegal accesses are detected without touching the bus.

---
 rtl/lsu_ctrl.sv | 215 +++++++++++++++++++++
 tb/tb_lsu_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store sequencer between the memory stage and a
// request/grant/response data bus.
//
// Ports:
//   clk, rst           single clock, synchronous active-high reset
//   memread_i/_write_i load / store request from decode/EX
//   funct3_i           access size and signedness
//   addr_i, wdata_i    effective byte address, store data
//   bus_req_o/we_o/addr_o/be_o/wdata_o  registered bus request fields
//   bus_gnt_i, bus_rvalid_i, bus_rdata_i bus grant and read response
//   stall_o            combinational pipeline hold
//   done_o, rdata_o    completion pulse, extended load result
//   err_o, timeout_o   illegal/misaligned and bus-timeout completions
//
// Optional feature: define LSU_TIMEOUT_EN to abort after TIMEOUT_CYC
// REQ or WAIT cycles. Without it the FSM waits indefinitely.
module lsu_ctrl #(
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memread_i,
  input  logic        memwrite_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [3:0]  bus_be_o,
  output logic [31:0] bus_wdata_o,
  input  logic        bus_gnt_i,
  input  logic        bus_rvalid_i,
  input  logic [31:0] bus_rdata_i,
  output logic        stall_o,
  output logic        done_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  output logic        timeout_o
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t      state;
  logic [2:0]  f3_q;
  logic [1:0]  alo_q;

  logic        access_c;
  logic        f3_ok_c;
  logic        misal_c;
  logic        illegal_c;
  logic [3:0]  be_c;
  logic [31:0] wdata_rep_c;
  logic [31:0] shifted_c;
  logic [31:0] ext_c;

  assign access_c = memread_i | memwrite_i;
  assign stall_o  = ((state == IDLE) & access_c) | (state == REQ) | (state == WAIT);

  // Access legality: funct3 decode plus natural alignment.
  always_comb begin
    f3_ok_c = 1'b0;
    case (funct3_i)
      3'b000, 3'b001, 3'b010: f3_ok_c = 1'b1;
      3'b100, 3'b101:         f3_ok_c = memread_i;
      default:                f3_ok_c = 1'b0;
    endcase
    misal_c = 1'b0;
    case (funct3_i[1:0])
      2'b01:   misal_c = addr_i[0];
      2'b10:   misal_c = |addr_i[1:0];
      default: misal_c = 1'b0;
    endcase
    illegal_c = (memread_i & memwrite_i) | ~f3_ok_c | misal_c;
  end

  // Byte enables and store-data lane replication.
  always_comb begin
    be_c        = 4'b1111;
    wdata_rep_c = wdata_i;
    case (funct3_i[1:0])
      2'b00: begin
        be_c        = 4'b0001 << addr_i[1:0];
        wdata_rep_c = {4{wdata_i[7:0]}};
      end
      2'b01: begin
        be_c        = 4'b0011 << {addr_i[1], 1'b0};
        wdata_rep_c = {2{wdata_i[15:0]}};
      end
      default: begin
        be_c        = 4'b1111;
        wdata_rep_c = wdata_i;
      end
    endcase
  end

  // Load alignment and extension from the latched funct3/offset.
  assign shifted_c = bus_rdata_i >> {alo_q, 3'b000};
  always_comb begin
    case (f3_q)
      3'b000:  ext_c = {{24{shifted_c[7]}},  shifted_c[7:0]};
      3'b001:  ext_c = {{16{shifted_c[15]}}, shifted_c[15:0]};
      3'b100:  ext_c = {24'd0, shifted_c[7:0]};
      3'b101:  ext_c = {16'd0, shifted_c[15:0]};
      default: ext_c = shifted_c;
    endcase
  end

`ifdef LSU_TIMEOUT_EN
  localparam int unsigned CntW = 8;
  logic [CntW-1:0] cnt;
  logic            expire_c;
  // Expiry is detected in the cycle whose increment reaches TIMEOUT_CYC.
  assign expire_c = (cnt == CntW'(TIMEOUT_CYC - 1));
`else
  // TIMEOUT_CYC only matters with the counter; the output stays low.
  assign timeout_o = 1'b0 & (TIMEOUT_CYC == 32'd0);
`endif

  // Sequencer FSM with registered bus and completion outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      f3_q        <= 3'd0;
      alo_q       <= 2'd0;
      bus_req_o   <= 1'b0;
      bus_we_o    <= 1'b0;
      bus_addr_o  <= 32'd0;
      bus_be_o    <= 4'd0;
      bus_wdata_o <= 32'd0;
      done_o      <= 1'b0;
      rdata_o     <= 32'd0;
      err_o       <= 1'b0;
`ifdef LSU_TIMEOUT_EN
      cnt         <= '0;
      timeout_o   <= 1'b0;
`endif
    end else begin
      done_o  <= 1'b0;
      err_o   <= 1'b0;
      rdata_o <= 32'd0;
`ifdef LSU_TIMEOUT_EN
      timeout_o <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (access_c) begin
            f3_q  <= funct3_i;
            alo_q <= addr_i[1:0];
            if (illegal_c) begin
              state  <= DONE;
              done_o <= 1'b1;
              err_o  <= 1'b1;
            end else begin
              state       <= REQ;
              bus_req_o   <= 1'b1;
              bus_we_o    <= memwrite_i;
              bus_addr_o  <= {addr_i[31:2], 2'b00};
              bus_be_o    <= be_c;
              bus_wdata_o <= wdata_rep_c;
`ifdef LSU_TIMEOUT_EN
              cnt         <= '0;
`endif
            end
          end
        end
        REQ: begin
`ifdef LSU_TIMEOUT_EN
          cnt <= cnt + CntW'(1);
`endif
          if (bus_gnt_i) begin
            bus_req_o <= 1'b0;
            if (bus_we_o) begin
              state  <= DONE;
              done_o <= 1'b1;
            end else begin
              state <= WAIT;
`ifdef LSU_TIMEOUT_EN
              cnt   <= '0;
`endif
            end
          end
`ifdef LSU_TIMEOUT_EN
          else if (expire_c) begin
            bus_req_o <= 1'b0;
            state     <= DONE;
            done_o    <= 1'b1;
            timeout_o <= 1'b1;
          end
`endif
        end
        WAIT: begin
`ifdef LSU_TIMEOUT_EN
          cnt <= cnt + CntW'(1);
`endif
          if (bus_rvalid_i) begin
            state   <= DONE;
            done_o  <= 1'b1;
            rdata_o <= ext_c;
          end
`ifdef LSU_TIMEOUT_EN
          else if (expire_c) begin
            state     <= DONE;
            done_o    <= 1'b1;
            timeout_o <= 1'b1;
          end
`endif
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: table-driven bench for lsu_ctrl with a small bus responder
// and a scoreboard queue of expected completions.
module tb_lsu_ctrl;

  localparam int unsigned TMO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        memread, memwrite;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_gnt, bus_rvalid;
  logic [31:0] bus_rdata;
  logic        stall, done, err, tmo;
  logic [31:0] rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lsu_ctrl #(.TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst(rst),
    .memread_i(memread), .memwrite_i(memwrite), .funct3_i(funct3),
    .addr_i(addr), .wdata_i(wdata),
    .bus_req_o(bus_req), .bus_we_o(bus_we), .bus_addr_o(bus_addr),
    .bus_be_o(bus_be), .bus_wdata_o(bus_wdata),
    .bus_gnt_i(bus_gnt), .bus_rvalid_i(bus_rvalid), .bus_rdata_i(bus_rdata),
    .stall_o(stall), .done_o(done), .rdata_o(rdata),
    .err_o(err), .timeout_o(tmo)
  );

  typedef struct {
    int          id;
    logic        rd, wr;
    logic [2:0]  f3;
    logic [31:0] addr, wdata, rdata;
    int          gnt_dly;   // REQ cycles before grant, -1 = never
    int          rv_dly;    // WAIT cycles before rvalid, -1 = never
    logic        early_rv;  // junk rvalid in the grant cycle
    logic [3:0]  be;
    logic [31:0] bwdata, xrdata;
    logic        xerr, xtmo;
    int          xcyc;      // cycle of done_o, access cycle = 1
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err, tmo;
    int          cyc;
  } exp_t;

  exp_t sb_q[$];
  vec_t vt[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(int id, logic rd, logic wr, logic [2:0] f3,
                              logic [31:0] a, logic [31:0] wd, logic [31:0] rdv,
                              int gd, int rvd, logic erv, logic [3:0] be,
                              logic [31:0] bwd, logic [31:0] xr, logic xe,
                              logic xt, int xc);
    vec_t v;
    v.id = id; v.rd = rd; v.wr = wr; v.f3 = f3; v.addr = a; v.wdata = wd;
    v.rdata = rdv; v.gnt_dly = gd; v.rv_dly = rvd; v.early_rv = erv;
    v.be = be; v.bwdata = bwd; v.xrdata = xr; v.xerr = xe; v.xtmo = xt;
    v.xcyc = xc;
    return v;
  endfunction

  task automatic bus_idle();
    bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'd0;
  endtask

  // Drives one access from IDLE, answers the bus, checks the completion.
  task automatic run_vec(input vec_t v);
    exp_t  e;
    int    cyc, req_cnt, wait_cnt, xreq;
    bit    granted, fin;
    string id;
    id = $sformatf("v%0d", v.id);
    memread = v.rd; memwrite = v.wr; funct3 = v.f3; addr = v.addr; wdata = v.wdata;
    e.rdata = v.xrdata; e.err = v.xerr; e.tmo = v.xtmo; e.cyc = v.xcyc;
    sb_q.push_back(e);
    #1 check({id, "_stall_req"}, 32'(stall), 32'd1);
    cyc = 1; req_cnt = 0; wait_cnt = 0; granted = 0; fin = 0;
    while (!fin && cyc < 100) begin
      @(posedge clk); #1; cyc++;
      bus_idle();
      if (done) begin
        fin = 1; memread = 1'b0; memwrite = 1'b0;
        if (sb_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL %s_sb: done_o with nothing expected", id);
        end else begin
          e = sb_q.pop_front();
          check({id, "_rdata"}, rdata, e.rdata);
          check({id, "_err"}, 32'(err), 32'(e.err));
          check({id, "_tmo"}, 32'(tmo), 32'(e.tmo));
          check({id, "_cyc"}, 32'(cyc), 32'(e.cyc));
          check({id, "_stall_done"}, 32'(stall), 32'd0);
          xreq = v.xerr ? 0 : (v.gnt_dly < 0 ? int'(TMO) : v.gnt_dly + 1);
          check({id, "_reqcyc"}, 32'(req_cnt), 32'(xreq));
        end
      end else if (bus_req) begin
        check({id, "_be"}, 32'(bus_be), 32'(v.be));
        check({id, "_baddr"}, bus_addr, v.addr & 32'hFFFF_FFFC);
        check({id, "_we"}, 32'(bus_we), 32'(v.wr));
        if (v.wr) check({id, "_bwdata"}, bus_wdata, v.bwdata);
        if (v.gnt_dly >= 0 && req_cnt >= v.gnt_dly) begin
          bus_gnt = 1'b1; granted = 1;
          if (v.early_rv) begin bus_rvalid = 1'b1; bus_rdata = 32'h5A5A_5A5A; end
        end
        req_cnt++;
      end else if (granted) begin
        if (v.rv_dly >= 0 && wait_cnt >= v.rv_dly) begin
          bus_rvalid = 1'b1; bus_rdata = v.rdata;
        end
        wait_cnt++;
      end
    end
    if (!fin) begin
      checks++; errors++;
      $display("FAIL %s_hang: no done_o within %0d cycles", id, cyc);
      sb_q.delete();
      memread = 1'b0; memwrite = 1'b0;
      rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
    end
    @(posedge clk); #1;
    bus_idle();
    check({id, "_idle_done"}, 32'(done), 32'd0);
    check({id, "_idle_req"}, 32'(bus_req), 32'd0);
    check({id, "_idle_stall"}, 32'(stall), 32'd0);
  endtask

  task automatic check_all_zero(input string nm);
    check({nm, "_req"}, 32'(bus_req), 32'd0);
    check({nm, "_we"}, 32'(bus_we), 32'd0);
    check({nm, "_addr"}, bus_addr, 32'd0);
    check({nm, "_be"}, 32'(bus_be), 32'd0);
    check({nm, "_wdata"}, bus_wdata, 32'd0);
    check({nm, "_done"}, 32'(done), 32'd0);
    check({nm, "_rdata"}, rdata, 32'd0);
    check({nm, "_err"}, 32'(err), 32'd0);
    check({nm, "_tmo"}, 32'(tmo), 32'd0);
    check({nm, "_stall"}, 32'(stall), 32'd0);
  endtask

  initial begin
    rst = 1'b1; memread = 1'b0; memwrite = 1'b0; funct3 = 3'd0;
    addr = 32'd0; wdata = 32'd0; bus_idle();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check_all_zero("rst");

    // Reset held two cycles while a store is in REQ.
    memwrite = 1'b1; funct3 = 3'b010; addr = 32'h0000_0100; wdata = 32'h1111_2222;
    @(posedge clk); #1;
    check("rstreq_inreq", 32'(bus_req), 32'd1);
    rst = 1'b1; memwrite = 1'b0;
    @(posedge clk); #1;
    check("rstreq_drop", 32'(bus_req), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    check_all_zero("rstreq");

    //           id rd wr f3      addr          wdata         rdata       gd rv erv be       bwdata        xrdata        xe xt cyc
    vt.push_back(mk(1, 0, 1, 3'b000, 32'h0000_1003, 32'h1234_56A5, 32'h0,        2, 0, 0, 4'b1000, 32'hA5A5_A5A5, 32'h0,        0, 0, 5));
    vt.push_back(mk(2, 0, 1, 3'b001, 32'h0000_2002, 32'hDEAD_BEEF, 32'h0,        0, 0, 0, 4'b1100, 32'hBEEF_BEEF, 32'h0,        0, 0, 3));
    vt.push_back(mk(3, 0, 1, 3'b010, 32'h0000_300C, 32'hCAFE_F00D, 32'h0,        1, 0, 0, 4'b1111, 32'hCAFE_F00D, 32'h0,        0, 0, 4));
    vt.push_back(mk(4, 1, 0, 3'b001, 32'h0000_2002, 32'h0,        32'h8001_1234, 0, 0, 0, 4'b1100, 32'h0,        32'hFFFF_8001, 0, 0, 4));
    vt.push_back(mk(5, 1, 0, 3'b101, 32'h0000_2002, 32'h0,        32'h8001_1234, 0, 0, 0, 4'b1100, 32'h0,        32'h0000_8001, 0, 0, 4));
    vt.push_back(mk(6, 1, 0, 3'b000, 32'h0000_5001, 32'h0,        32'h1234_8055, 1, 0, 1, 4'b0010, 32'h0,        32'hFFFF_FF80, 0, 0, 5));
    vt.push_back(mk(7, 1, 0, 3'b100, 32'h0000_5003, 32'h0,        32'h9A00_0000, 0, 2, 0, 4'b1000, 32'h0,        32'h0000_009A, 0, 0, 6));
    vt.push_back(mk(8, 1, 0, 3'b010, 32'h0000_6000, 32'h0,        32'h89AB_CDEF, 0, 0, 1, 4'b1111, 32'h0,        32'h89AB_CDEF, 0, 0, 4));
    vt.push_back(mk(9, 1, 0, 3'b000, 32'h0000_7000, 32'h0,        32'hFFFF_FF7F, 0, 0, 0, 4'b0001, 32'h0,        32'h0000_007F, 0, 0, 4));
    vt.push_back(mk(10, 1, 0, 3'b101, 32'h0000_2000, 32'h0,       32'h1234_F00D, 0, 0, 0, 4'b0011, 32'h0,        32'h0000_F00D, 0, 0, 4));
    vt.push_back(mk(11, 1, 0, 3'b001, 32'h0000_2000, 32'h0,       32'h1234_F00D, 0, 0, 0, 4'b0011, 32'h0,        32'hFFFF_F00D, 0, 0, 4));
    vt.push_back(mk(12, 1, 0, 3'b010, 32'h0000_3001, 32'h0,       32'h0,         0, 0, 0, 4'b0000, 32'h0,        32'h0,         1, 0, 2));
    vt.push_back(mk(13, 1, 1, 3'b010, 32'h0000_0100, 32'h0,       32'h0,         0, 0, 0, 4'b0000, 32'h0,        32'h0,         1, 0, 2));
    vt.push_back(mk(14, 1, 0, 3'b011, 32'h0000_0000, 32'h0,       32'h0,         0, 0, 0, 4'b0000, 32'h0,        32'h0,         1, 0, 2));
    vt.push_back(mk(15, 0, 1, 3'b001, 32'h0000_2001, 32'h0,       32'h0,         0, 0, 0, 4'b0000, 32'h0,        32'h0,         1, 0, 2));
    vt.push_back(mk(16, 0, 1, 3'b100, 32'h0000_0000, 32'h0,       32'h0,         0, 0, 0, 4'b0000, 32'h0,        32'h0,         1, 0, 2));
    vt.push_back(mk(17, 1, 0, 3'b101, 32'h0000_2003, 32'h0,       32'h0,         0, 0, 0, 4'b0000, 32'h0,        32'h0,         1, 0, 2));
    vt.push_back(mk(18, 0, 1, 3'b000, 32'h0000_1000, 32'h0000_007E, 32'h0,       0, 0, 0, 4'b0001, 32'h7E7E_7E7E, 32'h0,        0, 0, 3));
`ifdef LSU_TIMEOUT_EN
    // Timeout in REQ, timeout in WAIT, grant/rvalid on the expiry cycle.
    vt.push_back(mk(19, 1, 0, 3'b010, 32'h0000_4000, 32'h0,       32'h0,        -1, 0, 0, 4'b1111, 32'h0,        32'h0,         0, 1, 6));
    vt.push_back(mk(20, 1, 0, 3'b010, 32'h0000_4004, 32'h0,       32'hFFFF_FFFF, 0,-1, 0, 4'b1111, 32'h0,        32'h0,         0, 1, 7));
    vt.push_back(mk(21, 0, 1, 3'b010, 32'h0000_4008, 32'h1122_3344, 32'h0,       3, 0, 0, 4'b1111, 32'h1122_3344, 32'h0,        0, 0, 6));
    vt.push_back(mk(22, 1, 0, 3'b010, 32'h0000_400C, 32'h0,       32'h5566_7788, 0, 3, 0, 4'b1111, 32'h0,        32'h5566_7788, 0, 0, 7));
`else
    // Long grant latency completes normally without a timeout.
    vt.push_back(mk(19, 0, 1, 3'b010, 32'h0000_8000, 32'h0102_0304, 32'h0,      39, 0, 0, 4'b1111, 32'h0102_0304, 32'h0,        0, 0, 42));
`endif

    foreach (vt[i]) run_vec(vt[i]);

    if (sb_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL sb_left: %0d expected completions never seen", sb_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d errors so far", errors);
    $fatal(1, "watchdog");
  end

endmodule
